reel_spin_ctrl: RTL and testbench

- Sits directly downstream of the SPI command decoder and consumes its decoded outputs: reel targets, start_spin, win/total credits and their strobes.
- Animates three reels stepping through NUM_SYMBOLS symbols and stops them in staggered order on the commanded indices.
- Holds credit values for the display and returns a one-cycle done acknowledge for the MCU ack pin.

---
 rtl/reel_spin_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_reel_spin_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reel_spin_ctrl.sv
// reel_spin_ctrl: three-reel spin animator driven by the SPI command decoder.
//
// Animates three reels that step through NUM_SYMBOLS symbols, stops them in
// staggered order (1, 2, 3) on the latched target indices, holds the credit
// values for the display and returns a one-cycle done acknowledge.
//
// Optional feature: define REEL_DECEL_EN to run each reel at half speed during
// its final lap (advance on every second step tick only).
//
// Ports:
//   clk, reset_n                   system clock, asynchronous active-low reset
//   start_spin                     one-cycle spin request (accepted in IDLE only)
//   reel1_idx..reel3_idx           target stop positions (clamped to NUM_SYMBOLS-1)
//   is_win, win_credits            win strobe and value
//   is_total, total_credits        balance strobe and value
//   reel1_pos..reel3_pos           currently displayed symbol per reel
//   spinning                       high while in SPIN
//   done                           one-cycle pulse after the last reel stops
//   win_disp, total_disp           displayed win and balance
module reel_spin_ctrl #(
    parameter int unsigned NUM_SYMBOLS = 10,
    parameter int unsigned STEP_DIV    = 250000,
    parameter int unsigned MIN_LAPS    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_spin,
    input  logic [3:0]  reel1_idx,
    input  logic [3:0]  reel2_idx,
    input  logic [3:0]  reel3_idx,
    input  logic        is_win,
    input  logic [11:0] win_credits,
    input  logic        is_total,
    input  logic [11:0] total_credits,
    output logic [3:0]  reel1_pos,
    output logic [3:0]  reel2_pos,
    output logic [3:0]  reel3_pos,
    output logic        spinning,
    output logic        done,
    output logic [11:0] win_disp,
    output logic [11:0] total_disp
);

    localparam int unsigned     DivW    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);
    localparam logic [3:0]      PosLast = 4'(NUM_SYMBOLS - 1);
    localparam logic [3:0]      LapsMax = 4'd15;

    typedef enum logic [1:0] {StIdle, StSpin, StDone} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0][3:0] pos_q, pos_d;
    logic [2:0][3:0] tgt_q, tgt_d;
    logic [2:0][3:0] laps_q, laps_d;
    logic [2:0]      moving_q, moving_d;
    logic [11:0]     win_q, win_d;
    logic [11:0]     pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [11:0]     total_q, total_d;
    logic            tick;
    logic            order_ok;
    logic [2:0]      adv;
`ifdef REEL_DECEL_EN
    logic [2:0]      tog_q, tog_d;
`endif

    function automatic logic [3:0] clamp_tgt(input logic [3:0] idx);
        return (32'(idx) >= NUM_SYMBOLS) ? PosLast : idx;
    endfunction

    // Reel n (0-based here) needs MIN_LAPS + n completed laps before it may stop.
    function automatic logic lap_met(input logic [3:0] laps, input int unsigned reel);
        return 32'(laps) >= (MIN_LAPS + reel);
    endfunction

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pos_d      = pos_q;
        tgt_d      = tgt_q;
        laps_d     = laps_q;
        moving_d   = moving_q;
        win_d      = win_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        total_d    = total_q;
        adv        = '0;
        order_ok   = 1'b1;
`ifdef REEL_DECEL_EN
        tog_d      = tog_q;
`endif
        tick = (state_q == StSpin) && (div_q == DivLast);

        if (is_total) begin
            total_d = total_credits;
        end

        unique case (state_q)
            StIdle: begin
                if (start_spin) begin
                    state_d    = StSpin;
                    tgt_d[0]   = clamp_tgt(reel1_idx);
                    tgt_d[1]   = clamp_tgt(reel2_idx);
                    tgt_d[2]   = clamp_tgt(reel3_idx);
                    div_d      = '0;
                    laps_d     = '0;
                    moving_d   = 3'b111;
                    win_d      = '0;
                    // A win arriving with the spin request is held until the reels stop.
                    pend_d     = win_credits;
                    pend_vld_d = is_win;
`ifdef REEL_DECEL_EN
                    tog_d      = '0;
`endif
                end else if (is_win) begin
                    win_d = win_credits;
                end
            end

            StSpin: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (is_win) begin
                    pend_d     = win_credits;
                    pend_vld_d = 1'b1;
                end
                if (tick) begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (moving_q[i]) begin
`ifdef REEL_DECEL_EN
                            // Final lap: skip one tick, advance on the next.
                            if (lap_met(laps_q[i], i)) begin
                                tog_d[i] = ~tog_q[i];
                                adv[i]   = tog_q[i];
                            end else begin
                                adv[i] = 1'b1;
                            end
`else
                            adv[i] = 1'b1;
`endif
                            if (adv[i]) begin
                                pos_d[i] = (pos_q[i] == PosLast) ? 4'd0 : pos_q[i] + 4'd1;
                                if (pos_q[i] == PosLast && laps_q[i] != LapsMax) begin
                                    laps_d[i] = laps_q[i] + 4'd1;
                                end
                                // A reel may only stop once every lower-numbered reel has.
                                if (order_ok && pos_d[i] == tgt_q[i] && lap_met(laps_d[i], i)) begin
                                    moving_d[i] = 1'b0;
                                end
                            end
                        end
                        order_ok = ~moving_d[i];
                    end
                    if (moving_d == 3'b000) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d    = StIdle;
                // Reveal the win on the edge that enters IDLE.
                if (is_win) begin
                    win_d = win_credits;
                end else if (pend_vld_q) begin
                    win_d = pend_q;
                end
                pend_vld_d = 1'b0;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            pos_q      <= '0;
            tgt_q      <= '0;
            laps_q     <= '0;
            moving_q   <= '0;
            win_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            total_q    <= '0;
`ifdef REEL_DECEL_EN
            tog_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pos_q      <= pos_d;
            tgt_q      <= tgt_d;
            laps_q     <= laps_d;
            moving_q   <= moving_d;
            win_q      <= win_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            total_q    <= total_d;
`ifdef REEL_DECEL_EN
            tog_q      <= tog_d;
`endif
        end
    end

    assign reel1_pos  = pos_q[0];
    assign reel2_pos  = pos_q[1];
    assign reel3_pos  = pos_q[2];
    assign spinning   = (state_q == StSpin);
    assign done       = (state_q == StDone);
    assign win_disp   = win_q;
    assign total_disp = total_q;

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Self-checking bench for reel_spin_ctrl (NUM_SYMBOLS=10, STEP_DIV=4, MIN_LAPS=1).
// Expected spin results are pushed to a scoreboard when a spin is launched and
// popped by the monitor when done pulses.
module tb_reel_spin_ctrl;

    localparam int N  = 10;
    localparam int SD = 4;
    localparam int ML = 1;

    logic        clk;
    logic        reset_n;
    logic        start_spin;
    logic [3:0]  reel1_idx, reel2_idx, reel3_idx;
    logic        is_win;
    logic [11:0] win_credits;
    logic        is_total;
    logic [11:0] total_credits;
    logic [3:0]  reel1_pos, reel2_pos, reel3_pos;
    logic        spinning;
    logic        done;
    logic [11:0] win_disp;
    logic [11:0] total_disp;

    reel_spin_ctrl #(
        .NUM_SYMBOLS (N),
        .STEP_DIV    (SD),
        .MIN_LAPS    (ML)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_spin    (start_spin),
        .reel1_idx     (reel1_idx),
        .reel2_idx     (reel2_idx),
        .reel3_idx     (reel3_idx),
        .is_win        (is_win),
        .win_credits   (win_credits),
        .is_total      (is_total),
        .total_credits (total_credits),
        .reel1_pos     (reel1_pos),
        .reel2_pos     (reel2_pos),
        .reel3_pos     (reel3_pos),
        .spinning      (spinning),
        .done          (done),
        .win_disp      (win_disp),
        .total_disp    (total_disp)
    );

    typedef struct {
        int          p1, p2, p3;
        int          t1, t2, t3;
        logic [11:0] win;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   n_done;
    int   cyc = 0;
    int   cur1, cur2, cur3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tick-by-tick reference of one spin; returns final positions and stop ticks.
    function automatic exp_t model_spin(input int s1, input int s2, input int s3,
                                        input int g1, input int g2, input int g3,
                                        input logic [11:0] w);
        exp_t e;
        int   pos [3];
        int   tgt [3];
        int   laps [3];
        int   st [3];
        bit   half [3];
        bit   mov [3];
        bit   go;
        bit   prev_mov;
        pos[0] = s1; pos[1] = s2; pos[2] = s3;
        tgt[0] = (g1 >= N) ? N - 1 : g1;
        tgt[1] = (g2 >= N) ? N - 1 : g2;
        tgt[2] = (g3 >= N) ? N - 1 : g3;
        for (int r = 0; r < 3; r++) begin
            laps[r] = 0; st[r] = 0; half[r] = 1'b0; mov[r] = 1'b1;
        end
        for (int tk = 1; tk <= 2000; tk++) begin
            prev_mov = 1'b0;
            for (int r = 0; r < 3; r++) begin
                if (mov[r]) begin
                    go = 1'b1;
`ifdef REEL_DECEL_EN
                    if (laps[r] >= ML + r) begin
                        half[r] = !half[r];
                        go      = !half[r];
                    end
`endif
                    if (go) begin
                        pos[r] = (pos[r] + 1) % N;
                        if (pos[r] == 0 && laps[r] < 15) laps[r]++;
                        if (pos[r] == tgt[r] && laps[r] >= ML + r && !prev_mov) begin
                            mov[r] = 1'b0;
                            st[r]  = tk;
                        end
                    end
                end
                prev_mov = mov[r];
            end
        end
        e.p1 = pos[0]; e.p2 = pos[1]; e.p3 = pos[2];
        e.t1 = st[0];  e.t2 = st[1];  e.t3 = st[2];
        e.win = w;
        return e;
    endfunction

    task automatic launch(input int g1, input int g2, input int g3,
                          input bit track, input logic [11:0] w);
        exp_t e;
        reel1_idx  = 4'(g1);
        reel2_idx  = 4'(g2);
        reel3_idx  = 4'(g3);
        start_spin = 1'b1;
        if (track) begin
            e = model_spin(cur1, cur2, cur3, g1, g2, g3, w);
            sb.push_back(e);
            cur1 = e.p1; cur2 = e.p2; cur3 = e.p3;
        end
        step(1);
        start_spin = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            step(1);
            k++;
        end
        check_eq("done_seen", n_done, target);
    endtask

    task automatic monitor();
        logic [3:0] prv [3];
        logic [3:0] now [3];
        int         last [3];
        int         t0;
        logic       spin_prev;
        bit         post;
        exp_t       e;
        spin_prev = 1'b0;
        post      = 1'b0;
        t0        = 0;
        for (int r = 0; r < 3; r++) begin
            prv[r] = '0; last[r] = 0;
        end
        forever begin
            @(negedge clk);
            now[0] = reel1_pos; now[1] = reel2_pos; now[2] = reel3_pos;
            if (!reset_n) begin
                spin_prev = 1'b0;
                post      = 1'b0;
            end else begin
                if (spinning && !spin_prev) begin
                    t0 = cyc;
                    for (int r = 0; r < 3; r++) last[r] = cyc;
                end
                for (int r = 0; r < 3; r++) begin
                    if (now[r] != prv[r]) last[r] = cyc;
                end
                if (post) begin
                    check_eq("win_reveal", win_disp, e.win);
                    check_eq("done_width", done, 0);
                    check_eq("spin_after", spinning, 0);
                    post = 1'b0;
                end
                if (done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        check_eq("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("pos1", now[0], e.p1);
                        check_eq("pos2", now[1], e.p2);
                        check_eq("pos3", now[2], e.p3);
                        check_eq("stop1", last[0] - t0, e.t1 * SD);
                        check_eq("stop2", last[1] - t0, e.t2 * SD);
                        check_eq("stop3", last[2] - t0, e.t3 * SD);
                        check_eq("done_lat", cyc - t0, e.t3 * SD);
                        check_eq("spin_at_done", spinning, 0);
                        check_eq("win_hidden", win_disp, 0);
                        post = 1'b1;
                    end
                end
            end
            for (int r = 0; r < 3; r++) prv[r] = now[r];
            spin_prev = spinning;
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_done = 0;
        cur1 = 0; cur2 = 0; cur3 = 0;
        reset_n = 1'b0; start_spin = 1'b0;
        reel1_idx = '0; reel2_idx = '0; reel3_idx = '0;
        is_win = 1'b0; win_credits = '0; is_total = 1'b0; total_credits = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pos1", reel1_pos, 0);
        check_eq("rst_pos2", reel2_pos, 0);
        check_eq("rst_pos3", reel3_pos, 0);
        check_eq("rst_spin", spinning, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_win", win_disp, 0);
        check_eq("rst_total", total_disp, 0);
        reset_n = 1'b1;
        step(2);

        // Basic spin 3/3/7 with an ignored request at tick 5, a win and a balance update.
        launch(3, 3, 7, 1'b1, 12'h123);
        check_eq("spin_rise", spinning, 1);
        step(18);
        reel1_idx = 4'd9; reel2_idx = 4'd9; reel3_idx = 4'd9;
        start_spin = 1'b1;
        step(1);
        start_spin = 1'b0;
        step(5);
        is_win = 1'b1; win_credits = 12'h123;
        step(1);
        is_win = 1'b0;
        check_eq("win_pending", win_disp, 0);
        is_total = 1'b1; total_credits = 12'h456;
        check_eq("total_before", total_disp, 0);
        step(1);
        is_total = 1'b0;
        check_eq("total_update", total_disp, 12'h456);
        wait_done(1, 600);
        step(3);

        // Win in IDLE shows on the next edge; spin accept clears it.
        is_win = 1'b1; win_credits = 12'h0AB;
        step(1);
        is_win = 1'b0;
        check_eq("win_idle", win_disp, 12'h0AB);

        // Clamp: reel2 target 12 stops at 9.
        launch(5, 12, 2, 1'b1, 12'h000);
        check_eq("win_clear", win_disp, 0);
        wait_done(2, 800);
        step(3);

        // Reset in the middle of a spin aborts without a done pulse.
        launch(1, 1, 1, 1'b0, 12'h000);
        step(30);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_pos1", reel1_pos, 0);
        check_eq("arst_pos2", reel2_pos, 0);
        check_eq("arst_pos3", reel3_pos, 0);
        check_eq("arst_spin", spinning, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_win", win_disp, 0);
        check_eq("arst_total", total_disp, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cur1 = 0; cur2 = 0; cur3 = 0;
        step(200);
        check_eq("no_done_abort", n_done, 2);
        check_eq("idle_after_abort", spinning, 0);

        // Win with the start request goes pending; a later win overwrites it.
        is_win = 1'b1; win_credits = 12'h7FF;
        launch(0, 9, 5, 1'b1, 12'h321);
        is_win = 1'b0;
        check_eq("win_same_cycle", win_disp, 0);
        step(20);
        is_win = 1'b1; win_credits = 12'h321;
        step(1);
        is_win = 1'b0;
        wait_done(3, 800);
        step(3);

        check_eq("done_count", n_done, 3);
        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
